pipe_ctrl: RTL
==============

# pipe_ctrl

Central pipeline control for the five-stage MiniMIPS32 core: collects per-stage stall requests and the MEM-stage exception/ERET decision, and drives the `stall` bus and `flush` pulse consumed by every inter-stage register (PC, IF/ID, ID/EXE, EXE/MEM, MEM/WB). It also redirects fetch on flush and keeps a stall-cycle performance counter. Optionally, a watchdog converts an over-long MEM bus wait into a bus-error exception.

## Interface
- `TIMEOUT_CYCLES`, 255: consecutive MEM-stall cycles before the watchdog fires (8-bit; 1..255).
- `EXC_VECTOR`, 32'hBFC00380: general exception entry PC.
- `cpu_clk_50M`  in  1  core clock; all state updates on rising edge.
- `cpu_rst`  in  1  reset; one clock, synchronous, active-high.
- `stallreq_id`  in  1  load-use hazard in ID.
- `stallreq_exe`  in  1  multi-cycle EXE op busy.
- `stallreq_mem`  in  1  data bus not ready.
- `exc_req`  in  1  MEM-stage instruction takes an exception (non-ERET).
- `eret_req`  in  1  MEM-stage instruction is ERET.
- `cp0_epc`  in  32  current EPC.
- `stall`  out  6  [0]=PC … [5]=WB; 1 = STOP.
- `flush`  out  1  clears all inter-stage registers this edge.
- `flush_pc`  out  32  next fetch PC when `flush`=1; 0 otherwise.
- `buserr_exc`  out  1  watchdog-injected exception, one cycle; to CP0 (ExcCode 7).
- `stall_cycles`  out  32  count of cycles with `stall[0]`=1.

## Operation
- `stall`, `flush`, `flush_pc` are combinational from inputs and state; counters and FSM are registered.
- Priority: flush sources > MEM stall > EXE stall > ID stall.
- `stall` encoding: mem → 6'b011111; exe → 6'b001111; id → 6'b000111; none → 6'b000000.
- Any cycle with `flush`=1 forces `stall`=6'b000000.
- Flush sources: `buserr_exc`, then `exc_req` → `flush_pc`=`EXC_VECTOR`; `eret_req` (no `exc_req`/`buserr_exc`) → `flush_pc`=`cp0_epc`.
- `exc_req` and `eret_req` together: exception wins, vector used.
- FSM states: RUN, MEMWAIT, BUSERR.
  - RUN → MEMWAIT when `stallreq_mem`=1 and no flush; wait counter := 1.
  - MEMWAIT: counter +1 per cycle while `stallreq_mem`=1; → RUN when `stallreq_mem`=0 or flush arrives.
  - MEMWAIT → BUSERR when counter reaches `TIMEOUT_CYCLES` and `stallreq_mem` still 1.
  - BUSERR: `buserr_exc`=1, `flush`=1, `flush_pc`=`EXC_VECTOR` for exactly one cycle → RUN.
- `stall_cycles`: +1 each cycle `stall[0]`=1; wraps 32'hFFFFFFFF → 0; not incremented in flush cycles.

## Timing
- Reset (`cpu_rst`=1 at edge): FSM=RUN, wait counter=0, `stall_cycles`=0, `buserr_exc`=0; with inputs idle, `stall`=0, `flush`=0, `flush_pc`=0.
- Reset mid-MEMWAIT or in BUSERR: returns to RUN next edge; no `buserr_exc` emitted.
- Request → `stall` latency: 0 cycles (same cycle).
- `exc_req`/`eret_req` → `flush`: 0 cycles; stage registers clear at that edge; fetch at `flush_pc` next cycle.
- Watchdog: `stallreq_mem` high from cycle 0 gives `buserr_exc` in cycle `TIMEOUT_CYCLES`; in that cycle `stall`=0.
- `stallreq_mem` dropping in the same cycle the counter hits the limit: no timeout, → RUN.
- `stall_cycles` visible the cycle after the counted cycle.

## Configuration
- `PIPE_CTRL_TIMEOUT_EN` defined: MEMWAIT/BUSERR watchdog compiled in as above.
- Undefined: FSM stays in RUN, no wait counter, `buserr_exc` tied 0, MEM stalls indefinitely; all other behaviour identical.

## Test plan
- Reset then idle: `stall`=0, `flush`=0, `flush_pc`=0, `stall_cycles`=0.
- `stallreq_id`=1 three cycles, `stallreq_exe`=1 on the middle cycle → `stall`=000111, 001111, 000111; `stall_cycles`=3.
- `stallreq_mem`=1 with `exc_req`=1 same cycle → `flush`=1, `stall`=0, `flush_pc`=32'hBFC00380; `eret_req`=1 alone, `cp0_epc`=32'h80001234 → `flush_pc`=32'h80001234.
- Macro on, `TIMEOUT_CYCLES`=4, `stallreq_mem` held high → `stall`=011111 for cycles 0–3, cycle 4 `buserr_exc`=1, `flush`=1, `flush_pc`=32'hBFC00380, then RUN.
- Same as previous but `stallreq_mem` drops in cycle 4 → no `buserr_exc`; `cpu_rst` in cycle 2 → counter cleared, no `buserr_exc`.
- Macro off, `stallreq_mem` held 300 cycles → `stall`=011111 throughout, `buserr_exc` never 1, `stall_cycles`=300.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: MiniMIPS32 stall/flush control with stall-cycle counter.
// Define PIPE_CTRL_TIMEOUT_EN to compile in the MEM bus-wait watchdog.
module pipe_ctrl #(
  parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255,
  parameter logic [31:0] EXC_VECTOR     = 32'hBFC00380
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst,
  input  logic        stallreq_id,
  input  logic        stallreq_exe,
  input  logic        stallreq_mem,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] flush_pc,
  output logic        buserr_exc,
  output logic [31:0] stall_cycles
);
`ifdef PIPE_CTRL_TIMEOUT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif
  typedef enum logic [1:0] {RUN, MEMWAIT, BUSERR} state_t;
  state_t state, state_nxt;
  logic [7:0] wcnt, wcnt_nxt, wcnt_inc;
  // BUSERR means the wait count hit the limit; the exception fires only if the bus is still not ready
  always_comb begin
    buserr_exc = WD_EN && state == BUSERR && stallreq_mem && !cpu_rst;
    flush      = buserr_exc || exc_req || eret_req;
    flush_pc   = !flush ? 32'h0 : (eret_req && !exc_req && !buserr_exc) ? cp0_epc : EXC_VECTOR;
    stall      = flush ? 6'b000000 : stallreq_mem ? 6'b011111 : stallreq_exe ? 6'b001111 :
                 stallreq_id ? 6'b000111 : 6'b000000;
    wcnt_inc   = wcnt + 8'd1;
    state_nxt  = RUN;
    wcnt_nxt   = 8'd0;
    if (WD_EN && stallreq_mem && !flush) begin
      wcnt_nxt  = wcnt_inc;
      state_nxt = (wcnt_inc == TIMEOUT_CYCLES) ? BUSERR : MEMWAIT;
    end
  end
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state        <= RUN;
      wcnt         <= 8'd0;
      stall_cycles <= 32'd0;
    end else begin
      state        <= state_nxt;
      wcnt         <= wcnt_nxt;
      stall_cycles <= stall_cycles + {31'b0, stall[0]};
    end
  end
endmodule
